// File: rtl/alu_2020.sv
`default_nettype none
// ============================================================================
// Module   : alu_2020
// Purpose  : XLEN-bit integer ALU with NZVC flags and an invalid-opcode flag.
//            Combinational core. Input and output register stages are
//            optional and selected by parameters.
// Revision : 1.0  initial release
// ============================================================================
module alu_2020 #(
   parameter int XLEN   = 32,
   parameter int REGIN  = 0,
   parameter int REGOUT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      op,
   output logic [XLEN-1:0] s,
   output logic            n,
   output logic            z,
   output logic            v,
   output logic            c,
   output logic            hata
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_NOR   = 4'b0101;
   localparam logic [3:0] OP_SLL   = 4'b0110;
   localparam logic [3:0] OP_SRL   = 4'b0111;
   localparam logic [3:0] OP_SRA   = 4'b1000;
   localparam logic [3:0] OP_SLT   = 4'b1001;
   localparam logic [3:0] OP_SLTU  = 4'b1010;
   localparam logic [3:0] OP_PASSB = 4'b1011;

   // Operands as seen by the combinational core
   logic [XLEN-1:0] a_i;
   logic [XLEN-1:0] b_i;
   logic [3:0]      op_i;

   // Core results before the optional output stage
   logic [XLEN-1:0] s_d;
   logic            n_d;
   logic            z_d;
   logic            v_d;
   logic            c_d;
   logic            hata_d;

   // Shared adder: SUB is a + ~b + 1, so one carry chain serves both ops
   logic [XLEN-1:0] addend;
   logic            cin;
   logic [XLEN:0]   sum;
   logic [SHW-1:0]  sh;

   generate
      if (REGIN != 0) begin : g_regin
         logic [XLEN-1:0] a_q;
         logic [XLEN-1:0] b_q;
         logic [3:0]      op_q;

         // Input stage; reset loads a=0, b=0, op=ADD
         always_ff @(posedge clk) begin
            if (rst) begin
               a_q  <= '0;
               b_q  <= '0;
               op_q <= OP_ADD;
            end else begin
               a_q  <= a;
               b_q  <= b;
               op_q <= op;
            end
         end

         assign a_i  = a_q;
         assign b_i  = b_q;
         assign op_i = op_q;
      end else begin : g_passin
         assign a_i  = a;
         assign b_i  = b;
         assign op_i = op;
      end
   endgenerate

   assign addend = (op_i == OP_SUB) ? ~b_i : b_i;
   assign cin    = (op_i == OP_SUB);
   assign sum    = {1'b0, a_i} + {1'b0, addend} + {{XLEN{1'b0}}, cin};
   assign sh     = b_i[SHW-1:0];

   // Result mux and flag generation; invalid opcodes force everything to 0
   always_comb begin
      s_d    = '0;
      v_d    = 1'b0;
      c_d    = 1'b0;
      hata_d = 1'b0;
      case (op_i)
         OP_ADD, OP_SUB: begin
            s_d = sum[XLEN-1:0];
            c_d = sum[XLEN];
            v_d = (a_i[XLEN-1] == addend[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]);
         end
         OP_AND:   s_d = a_i & b_i;
         OP_OR:    s_d = a_i | b_i;
         OP_XOR:   s_d = a_i ^ b_i;
         OP_NOR:   s_d = ~(a_i | b_i);
         OP_SLL:   s_d = a_i << sh;
         OP_SRL:   s_d = a_i >> sh;
         OP_SRA:   s_d = $unsigned($signed(a_i) >>> sh);
         OP_SLT:   s_d = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         OP_SLTU:  s_d = {{(XLEN-1){1'b0}}, (a_i < b_i)};
         OP_PASSB: s_d = b_i;
         default:  hata_d = 1'b1;
      endcase
   end

   assign n_d = hata_d ? 1'b0 : s_d[XLEN-1];
   assign z_d = hata_d ? 1'b0 : (s_d == '0);

   generate
      if (REGOUT != 0) begin : g_regout
         // Output stage; reset clears all outputs, z included
         always_ff @(posedge clk) begin
            if (rst) begin
               s    <= '0;
               n    <= 1'b0;
               z    <= 1'b0;
               v    <= 1'b0;
               c    <= 1'b0;
               hata <= 1'b0;
            end else begin
               s    <= s_d;
               n    <= n_d;
               z    <= z_d;
               v    <= v_d;
               c    <= c_d;
               hata <= hata_d;
            end
         end
      end else begin : g_passout
         assign s    = s_d;
         assign n    = n_d;
         assign z    = z_d;
         assign v    = v_d;
         assign c    = c_d;
         assign hata = hata_d;
      end
   endgenerate

   generate
      if (REGIN == 0 && REGOUT == 0) begin : g_noclk
         // clk and rst have no load in the purely combinational build
         logic unused_clkrst;
         assign unused_clkrst = &{1'b0, clk, rst};
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alu_2020.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_2020
// Purpose  : Self-checking bench for alu_2020 (XLEN=32, unregistered).
//            Directed corner cases plus random stimulus against a reference
//            model built from signed/unsigned 64-bit arithmetic.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_2020;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  op;
   logic [31:0] s;
   logic        n;
   logic        z;
   logic        v;
   logic        c;
   logic        hata;

   int tests_run;
   int tests_failed;

   alu_2020 #(.XLEN(32), .REGIN(0), .REGOUT(0)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .op  (op),
      .s   (s),
      .n   (n),
      .z   (z),
      .v   (v),
      .c   (c),
      .hata(hata)
   );

   // Free-running clock (unused by the combinational build)
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: op=%b a=%h b=%h got=%h expected=%h", tag, op, a, b, got, exp);
      end
   endtask

   // Reference: returns {hata, n, z, v, c, s}
   function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic [3:0] o);
      longint      sx;
      longint      sy;
      longint      wide;
      logic [63:0] u;
      logic [31:0] r;
      logic        fv;
      logic        fc;
      logic        err;
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      r    = '0;
      fv   = 1'b0;
      fc   = 1'b0;
      err  = 1'b0;
      case (o)
         4'd0: begin
            u    = {32'd0, x} + {32'd0, y};
            r    = u[31:0];
            fc   = u[32];
            wide = sx + sy;
            fv   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         4'd1: begin
            u    = {32'd0, x} - {32'd0, y};
            r    = u[31:0];
            fc   = (x >= y);
            wide = sx - sy;
            fv   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         4'd2:  r = x & y;
         4'd3:  r = x | y;
         4'd4:  r = x ^ y;
         4'd5:  r = ~(x | y);
         4'd6:  r = x * (32'd1 << y[4:0]);
         4'd7:  r = x / (32'd1 << y[4:0]);
         4'd8: begin
            // floor division by a power of two is an arithmetic right shift
            wide = sx / (64'sd1 << y[4:0]);
            if (sx < 0 && (sx % (64'sd1 << y[4:0])) != 0) wide = wide - 1;
            r = wide[31:0];
         end
         4'd9:  r = (sx < sy) ? 32'd1 : 32'd0;
         4'd10: r = (x < y) ? 32'd1 : 32'd0;
         4'd11: r = y;
         default: err = 1'b1;
      endcase
      if (err) return {1'b1, 4'b0000, 32'd0};
      return {1'b0, r[31], (r == 32'd0), fv, fc, r};
   endfunction

   task automatic run_case(input string tag, input logic [3:0] o,
                           input logic [31:0] x, input logic [31:0] y);
      logic [36:0] exp;
      op = o;
      a  = x;
      b  = y;
      #10;
      exp = model(x, y, o);
      check({tag, ".s"},     {32'd0, s}, {32'd0, exp[31:0]});
      check({tag, ".flags"}, {59'd0, hata, n, z, v, c}, {59'd0, exp[36:32]});
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst = 1'b1;
      a   = '0;
      b   = '0;
      op  = 4'd0;
      #10;
      // All-zero ADD: s=0, z=1
      check("idle.s", {32'd0, s}, 64'd0);
      check("idle.flags", {59'd0, hata, n, z, v, c}, 64'b00100);
      rst = 1'b0;

      // Directed corners with hard-coded expectations
      op = 4'd0; a = 32'h7FFF_FFFF; b = 32'h1; #10;
      check("add_ovf.s", {32'd0, s}, 64'h8000_0000);
      check("add_ovf.nzvc", {60'd0, n, z, v, c}, 64'b1010);
      op = 4'd0; a = 32'hFFFF_FFFF; b = 32'h1; #10;
      check("add_wrap.s", {32'd0, s}, 64'd0);
      check("add_wrap.nzvc", {60'd0, n, z, v, c}, 64'b0101);
      op = 4'd1; a = 32'd5; b = 32'd5; #10;
      check("sub_eq.s", {32'd0, s}, 64'd0);
      check("sub_eq.nzvc", {60'd0, n, z, v, c}, 64'b0101);
      op = 4'd1; a = 32'd0; b = 32'd1; #10;
      check("sub_borrow.s", {32'd0, s}, 64'hFFFF_FFFF);
      check("sub_borrow.nzvc", {60'd0, n, z, v, c}, 64'b1000);
      op = 4'd1; a = 32'h8000_0000; b = 32'd1; #10;
      check("sub_ovf.s", {32'd0, s}, 64'h7FFF_FFFF);
      check("sub_ovf.nzvc", {60'd0, n, z, v, c}, 64'b0011);
      a = 32'hF0F0_F0F0; b = 32'hFF00_FF00;
      op = 4'd2; #10; check("and.s", {32'd0, s}, 64'hF000_F000);
      check("and.vc", {62'd0, v, c}, 64'd0);
      op = 4'd3; #10; check("or.s",  {32'd0, s}, 64'hFFF0_FFF0);
      check("or.vc", {62'd0, v, c}, 64'd0);
      op = 4'd4; #10; check("xor.s", {32'd0, s}, 64'h0FF0_0FF0);
      check("xor.vc", {62'd0, v, c}, 64'd0);
      op = 4'd5; #10; check("nor.s", {32'd0, s}, 64'h000F_000F);
      check("nor.vc", {62'd0, v, c}, 64'd0);
      op = 4'd8; a = 32'h8000_0000; b = 32'd4; #10;
      check("sra.s", {32'd0, s}, 64'hF800_0000);
      check("sra.n", {63'd0, n}, 64'd1);
      op = 4'd7; #10; check("srl.s", {32'd0, s}, 64'h0800_0000);
      op = 4'd6; a = 32'd1; b = 32'd31; #10; check("sll31.s", {32'd0, s}, 64'h8000_0000);
      op = 4'd6; a = 32'd1; b = 32'd32; #10; check("sll32.s", {32'd0, s}, 64'd1);
      op = 4'd9; a = 32'hFFFF_FFFF; b = 32'd1; #10; check("slt.s", {32'd0, s}, 64'd1);
      op = 4'd10; #10;
      check("sltu.s", {32'd0, s}, 64'd0);
      check("sltu.z", {63'd0, z}, 64'd1);
      for (int i = 12; i < 16; i++) begin
         op = 4'(i); a = $urandom; b = $urandom; #10;
         check("inv.s", {32'd0, s}, 64'd0);
         check("inv.flags", {59'd0, hata, n, z, v, c}, 64'b10000);
      end
      op = 4'd11; a = 32'd3; b = 32'h1234; #10;
      check("after_inv.hata", {63'd0, hata}, 64'd0);
      check("passb.s", {32'd0, s}, 64'h1234);

      // Random sweep against the model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] x;
         logic [31:0] y;
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 3))
            0: x = $urandom_range(0, 3);
            1: y = x;
            2: y = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'h7FFF_FFFF ^ 31'($urandom_range(0, 2))};
            default: ;
         endcase
         run_case("rand", 4'($urandom_range(0, 15)), x, y);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_2020.md
# alu_2020

Parameterised XLEN-bit integer ALU with NZVC status flags and an invalid-opcode error output. It is the datapath execution unit: purely combinational by default, with optional input and output register stages selected by parameters. The auto-checking bench runs it in the unregistered configuration with XLEN=32.

## Interface
- XLEN, 32: operand/result width in bits (≥ 2, power of two).
- REGIN, 0: 1 = register a, b, op on clk before the logic; 0 = pass through.
- REGOUT, 0: 1 = register s, n, z, v, c, hata on clk; 0 = combinational outputs.
- Parameter order is XLEN, REGIN, REGOUT (positional instantiation).

Ports:
- clk  in  1  clock; used only when REGIN or REGOUT = 1.
- rst  in  1  reset; synchronous and active-high.
- a  in  XLEN  operand A.
- b  in  XLEN  operand B; the shift amount is b[$clog2(XLEN)-1:0].
- op  in  4  operation select.
- s  out  XLEN  result.
- n  out  1  negative flag.
- z  out  1  zero flag.
- v  out  1  signed-overflow flag.
- c  out  1  carry flag.
- hata  out  1  invalid-opcode error.

## Operation
Opcodes:
- 0000 ADD: s = a+b.
- 0001 SUB: s = a−b, computed as a + ~b + 1.
- 0010 AND.
- 0011 OR.
- 0100 XOR.
- 0101 NOR.
- 0110 SLL: s = a << sh.
- 0111 SRL: logical right shift of a by sh.
- 1000 SRA: arithmetic right shift of a by sh.
- 1001 SLT: s = 1 if signed a < b, else 0.
- 1010 SLTU: s = 1 if unsigned a < b, else 0.
- 1011 PASSB: s = b.
- 1100–1111: invalid.

Flags for every valid op:
- n = s[XLEN-1].
- z = (s == 0).

Flags for ADD/SUB only:
- c = carry out of bit XLEN-1 of the adder. For SUB, c = 1 means no borrow (a ≥ b unsigned).
- v = 1 when both adder operands have the same sign and the sign of s differs. For SUB the adder operands are a and ~b.

All other valid ops: v = 0, c = 0.

Invalid op:
- hata = 1, s = 0, n = z = v = c = 0.
- No state is affected.
- hata = 0 for all valid ops.

Arithmetic rules:
- All arithmetic is modulo 2^XLEN.
- Shift amounts are never clamped; only the low $clog2(XLEN) bits of b are used.

## Timing
- REGIN=0, REGOUT=0: fully combinational, zero latency. Outputs are valid after propagation delay; clk and rst are ignored.
- Each enabled register stage adds one clk cycle of latency. Total latency is REGIN + REGOUT cycles.
- Operand/op changes take effect on the rising edge after they are applied.
- Synchronous reset: when rst = 1 at a rising edge, every enabled register loads 0.
  - After reset with REGOUT=1: s=0, n=0, z=0, v=0, c=0, hata=0. z is forced to 0 and is not recomputed from s.
  - With REGIN=1 and REGOUT=0, the outputs reflect a=0, b=0, op=ADD after reset: s=0, z=1.
- rst has priority over new data at the same edge. Data captured during a reset cycle is discarded.
- Back-to-back operations are accepted every cycle; there is no handshake or stall.

## Test plan
Bench configuration: XLEN=32, REGIN=0, REGOUT=0. Check each case 10 ns after applying stimulus.
- ADD: a=0x7FFFFFFF, b=0x00000001 -> s=0x80000000, nzvc=1010. Also a=0xFFFFFFFF, b=1 -> s=0, nzvc=0101.
- SUB: a=5, b=5 -> s=0, nzvc=0101. Also a=0, b=1 -> s=0xFFFFFFFF, nzvc=1000. Also a=0x80000000, b=1 -> s=0x7FFFFFFF, nzvc=0011.
- Logic: AND/OR/XOR/NOR with a=0xF0F0F0F0, b=0xFF00FF00 -> s = 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0 / 0x000F000F; v=c=0 in every case.
- Shifts/compare, part 1:
  - SRA a=0x80000000, b=4 -> s=0xF8000000, n=1.
  - SRL same operands -> s=0x08000000.
  - SLL a=1, b=31 -> s=0x80000000.
  - SLL a=1, b=32 -> s=1 (only the low 5 bits of b are used).
- Shifts/compare, part 2:
  - SLT a=0xFFFFFFFF, b=1 -> s=1.
  - SLTU same operands -> s=0, z=1.
- Invalid ops: op=1100..1111 with arbitrary a, b -> hata=1, s=0, nzvc=0000. The next valid op -> hata=0.
- Registered build (REGIN=1, REGOUT=1):
  - Holding rst=1 for 2 edges -> all outputs 0.
  - ADD 2+3 applied at edge k -> s=5 visible after edge k+2.
  - Asserting rst mid-stream clears both stages on the next edge.
